// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, inverse gain, internal width, FSM states.
// Phase format matches the rotation-mode generator: 2^16 = 360 degrees.
package cordic_pkg;

  localparam int W = 18;

  localparam logic [15:0] GAIN_INV = 16'd19898;

  localparam logic [15:0] ATAN_TAB [0:15] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297,
    16'd651,  16'd326,  16'd163,  16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,
    16'd3,    16'd1,    16'd1,    16'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring micro-rotation: drives y toward zero, accumulates angle in z.
// Shifts are arithmetic; z wraps modulo 2^16.
module cordic_vec_step
  import cordic_pkg::*;
(
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic [15:0]         z,
  input  logic [3:0]          sh,
  output logic signed [W-1:0] x_nxt,
  output logic signed [W-1:0] y_nxt,
  output logic [15:0]         z_nxt
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  assign x_sh = x >>> sh;
  assign y_sh = y >>> sh;

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (!y[W-1]) begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + ATAN_TAB[sh];
    end else begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - ATAN_TAB[sh];
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring engine: (X, Y) -> (angle, magnitude), one micro-rotation per cycle.
// Optional gain compensation stage selected by macro CORDIC_GAIN_COMP_EN.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 16
) (
  input  logic               Clk_i,
  input  logic               Rst_i,
  input  logic signed [15:0] X_i,
  input  logic signed [15:0] Y_i,
  input  logic               In_valid_i,
  output logic               In_ready_o,
  output logic [15:0]        Angle_o,
  output logic [16:0]        Mag_o,
  output logic               Out_valid_o,
  input  logic               Out_ready_i
);

  state_t state, state_nxt;

  logic signed [W-1:0] x, y, x_nxt, y_nxt;
  logic signed [W-1:0] x_ext, y_ext;
  logic [15:0]         z, z_nxt;
  logic [4:0]          i;
  logic                zero_in;
  logic                accept;
  logic                load_res;
  logic                iter_end;
  logic [16:0]         mag_res;

  assign x_ext    = {{(W-16){X_i[15]}}, X_i};
  assign y_ext    = {{(W-16){Y_i[15]}}, Y_i};
  assign accept   = (state == ST_IDLE) && In_valid_i;
  assign iter_end = (i == 5'(ITERATIONS));
  assign load_res = (state != ST_DONE) && (state_nxt == ST_DONE);

  cordic_vec_step u_step (
    .x     (x),
    .y     (y),
    .z     (z),
    .sh    (i[3:0]),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

`ifdef CORDIC_GAIN_COMP_EN
  // x is non-negative after convergence, so a signed Q1.15 product with rounding is exact enough
  logic signed [34:0] prod;
  logic signed [34:0] prod_rnd;
  logic               unused_prod;
  assign prod        = x * $signed({1'b0, GAIN_INV});
  assign prod_rnd    = prod + 35'sd16384;
  assign mag_res     = prod_rnd[31:15];
  assign unused_prod = ^{prod_rnd[34:32], prod_rnd[14:0]};
`else
  assign mag_res = x[16:0];
`endif

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (In_valid_i) state_nxt = ST_ITER;
      ST_ITER: begin
        if (iter_end) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt = ST_COMP;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_DONE: if (Out_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_DONE;
    endcase
  end

  always_comb begin
    In_ready_o = (state == ST_IDLE);
  end

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      x           <= '0;
      y           <= '0;
      z           <= '0;
      i           <= '0;
      zero_in     <= 1'b0;
      Angle_o     <= '0;
      Mag_o       <= '0;
      Out_valid_o <= 1'b0;
    end else begin
      if (accept) begin
        // Fold the left half-plane onto the right so the iterations always converge
        if (X_i[15]) begin
          x <= -x_ext;
          y <= -y_ext;
          z <= 16'd32768;
        end else begin
          x <= x_ext;
          y <= y_ext;
          z <= 16'd0;
        end
        i       <= '0;
        zero_in <= (X_i == 16'sd0) && (Y_i == 16'sd0);
      end else if (state == ST_ITER && !iter_end) begin
        x <= x_nxt;
        y <= y_nxt;
        z <= z_nxt;
        i <= i + 5'd1;
      end

      if (load_res) begin
        Out_valid_o <= 1'b1;
        Angle_o     <= zero_in ? 16'd0 : z;
        Mag_o       <= zero_in ? 17'd0 : mag_res;
      end else if (state == ST_DONE && Out_ready_i) begin
        Out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Table-driven and randomized check of cordic_vector against an atan2/sqrt reference.
// Follows CORDIC_GAIN_COMP_EN for expected latency and magnitude scaling.
module tb_cordic_vector;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT  = 18;
  localparam int  M1   = 16384;
  localparam int  M3   = 23170;
  localparam int  M4   = 32768;
  localparam bit  COMP = 1'b1;
`else
  localparam int  LAT  = 17;
  localparam int  M1   = 26981;
  localparam int  M3   = 38156;
  localparam int  M4   = 53963;
  localparam bit  COMP = 1'b0;
`endif
  localparam real PI = 3.14159265358979;

  logic               Clk_i = 1'b0;
  logic               Rst_i = 1'b0;
  logic signed [15:0] X_i = '0;
  logic signed [15:0] Y_i = '0;
  logic               In_valid_i = 1'b0;
  logic               In_ready_o;
  logic [15:0]        Angle_o;
  logic [16:0]        Mag_o;
  logic               Out_valid_o;
  logic               Out_ready_i = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  cordic_vector dut (
    .Clk_i       (Clk_i),
    .Rst_i       (Rst_i),
    .X_i         (X_i),
    .Y_i         (Y_i),
    .In_valid_i  (In_valid_i),
    .In_ready_o  (In_ready_o),
    .Angle_o     (Angle_o),
    .Mag_o       (Mag_o),
    .Out_valid_o (Out_valid_o),
    .Out_ready_i (Out_ready_i)
  );

  always #5 Clk_i = ~Clk_i;

  typedef struct {
    int x;
    int y;
    int ang;
    int alt;
    int atol;
    int mag;
    int mtol;
  } vec_t;

  function automatic real wrap_diff(real a, real b);
    real d = a - b;
    while (d > 32768.0)   d = d - 65536.0;
    while (d <= -32768.0) d = d + 65536.0;
    return (d < 0.0) ? -d : d;
  endfunction

  function automatic real ideal_angle(int x, int y);
    real a = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
    if (a < 0.0) a = a + 65536.0;
    return a;
  endfunction

  function automatic real ideal_mag(int x, int y);
    real k = 1.0;
    for (int s = 0; s < 16; s++) k = k * $sqrt(1.0 + 1.0 / (4.0 ** s));
    if (COMP) k = k * 19898.0 / 32768.0;
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * k;
  endfunction

  task automatic chk(input string nm, input int act, input real exp, input real tol, input bit circ);
    real d;
    d = circ ? wrap_diff(real'(act), exp) : ((real'(act) > exp) ? real'(act) - exp : exp - real'(act));
    n_vec++;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0.1f +-%0.1f", nm, act, exp, tol);
    end
  endtask

  task automatic chk_eq(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!Out_valid_o && lat < 100) begin
      @(posedge Clk_i); #1;
      lat++;
    end
  endtask

  task automatic run_sample(input int x, input int y, output int ang, output int mag, output int lat);
    int n;
    @(negedge Clk_i);
    X_i = 16'(x); Y_i = 16'(y); In_valid_i = 1'b1; Out_ready_i = 1'b0;
    n = 0;
    while (!In_ready_o && n < 100) begin
      @(negedge Clk_i);
      n++;
    end
    @(posedge Clk_i); #1;
    In_valid_i = 1'b0;
    wait_valid(lat);
    ang = int'(Angle_o);
    mag = int'(Mag_o);
    @(negedge Clk_i); Out_ready_i = 1'b1;
    @(posedge Clk_i); #1; Out_ready_i = 1'b0;
  endtask

  initial begin
    vec_t tab[6];
    int ang, mag, lat;
    int rx, ry, a0, m0, big, other;

    tab[0] = '{x:16384,  y:0,      ang:0,     alt:0,     atol:2, mag:M1, mtol:4};
    tab[1] = '{x:0,      y:16384,  ang:16384, alt:16384, atol:2, mag:M1, mtol:4};
    tab[2] = '{x:-16384, y:-16384, ang:40960, alt:40960, atol:2, mag:M3, mtol:6};
    tab[3] = '{x:-32768, y:0,      ang:32768, alt:32768, atol:2, mag:M4, mtol:6};
    tab[4] = '{x:16384,  y:-1,     ang:65535, alt:0,     atol:0, mag:M1, mtol:4};
    tab[5] = '{x:0,      y:0,      ang:0,     alt:0,     atol:0, mag:0,  mtol:0};

    #3;
    chk_eq("reset In_ready_o", int'(In_ready_o), 1);
    chk_eq("reset Out_valid_o", int'(Out_valid_o), 0);
    chk_eq("reset Angle_o", int'(Angle_o), 0);
    chk_eq("reset Mag_o", int'(Mag_o), 0);
    @(negedge Clk_i); Rst_i = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_sample(tab[k].x, tab[k].y, ang, mag, lat);
      n_vec++;
      if (!(wrap_diff(real'(ang), real'(tab[k].ang)) <= real'(tab[k].atol) || ang == tab[k].alt)) begin
        n_bad++;
        $display("FAIL table[%0d] angle: got %0d, want %0d +-%0d (or %0d)", k, ang, tab[k].ang, tab[k].atol, tab[k].alt);
      end
      chk($sformatf("table[%0d] mag", k), mag, real'(tab[k].mag), real'(tab[k].mtol), 1'b0);
      chk_eq($sformatf("table[%0d] latency", k), lat, LAT);
    end

    // Randomized samples with magnitude large enough for the ±3 LSB angle bound
    for (int k = 0; k < 24; k++) begin
      big   = int'($urandom_range(16384, 32767));
      other = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 1) == 1) big = -big;
      if ($urandom_range(0, 1) == 1) begin rx = big; ry = other; end
      else begin rx = other; ry = big; end
      run_sample(rx, ry, ang, mag, lat);
      chk($sformatf("rand(%0d,%0d) angle", rx, ry), ang, ideal_angle(rx, ry), 3.0, 1'b1);
      chk($sformatf("rand(%0d,%0d) mag", rx, ry), mag, ideal_mag(rx, ry), 10.0, 1'b0);
    end

    // Back-pressure with a second sample already waiting on the input
    @(negedge Clk_i);
    X_i = 16'sd12000; Y_i = 16'sd9000; In_valid_i = 1'b1; Out_ready_i = 1'b0;
    @(posedge Clk_i); #1;
    X_i = -16'sd5000; Y_i = 16'sd20000;
    wait_valid(lat);
    chk_eq("bp first latency", lat, LAT);
    a0 = int'(Angle_o);
    m0 = int'(Mag_o);
    chk("bp first angle", a0, ideal_angle(12000, 9000), 3.0, 1'b1);
    chk("bp first mag", m0, ideal_mag(12000, 9000), 10.0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk_i); #1;
      chk_eq("bp stall Angle_o", int'(Angle_o), a0);
      chk_eq("bp stall Mag_o", int'(Mag_o), m0);
      chk_eq("bp stall Out_valid_o", int'(Out_valid_o), 1);
      chk_eq("bp stall In_ready_o", int'(In_ready_o), 0);
    end
    @(negedge Clk_i); Out_ready_i = 1'b1;
    @(posedge Clk_i); #1; Out_ready_i = 1'b0;
    chk_eq("bp release Out_valid_o", int'(Out_valid_o), 0);
    chk_eq("bp release In_ready_o", int'(In_ready_o), 1);
    @(posedge Clk_i); #1;
    chk_eq("bp second accepted", int'(In_ready_o), 0);
    In_valid_i = 1'b0;
    wait_valid(lat);
    chk_eq("bp second latency", lat, LAT);
    chk("bp second angle", int'(Angle_o), ideal_angle(-5000, 20000), 3.0, 1'b1);
    chk("bp second mag", int'(Mag_o), ideal_mag(-5000, 20000), 10.0, 1'b0);
    @(negedge Clk_i); Out_ready_i = 1'b1;
    @(posedge Clk_i); #1; Out_ready_i = 1'b0;

    // Reset in the middle of the iterations; previous result is still on the outputs
    @(negedge Clk_i);
    X_i = 16'sd7000; Y_i = -16'sd15000; In_valid_i = 1'b1;
    @(posedge Clk_i); #1; In_valid_i = 1'b0;
    repeat (7) @(posedge Clk_i);
    #3; Rst_i = 1'b0;
    #1;
    chk_eq("mid reset Out_valid_o", int'(Out_valid_o), 0);
    chk_eq("mid reset In_ready_o", int'(In_ready_o), 1);
    chk_eq("mid reset Angle_o", int'(Angle_o), 0);
    chk_eq("mid reset Mag_o", int'(Mag_o), 0);
    @(negedge Clk_i); Rst_i = 1'b1;
    run_sample(-20000, -7000, ang, mag, lat);
    chk("post reset angle", ang, ideal_angle(-20000, -7000), 3.0, 1'b1);
    chk("post reset mag", mag, ideal_mag(-20000, -7000), 10.0, 1'b0);
    chk_eq("post reset latency", lat, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
